uart_tx_periph: RTL and testbench

Memory-mapped UART transmitter on the CPU data bus, a sibling consumer of the CPU store path alongside the LED output peripheral. Decodes `address_data[9:0]`, `data_out`, `width` and `write_mem`. Queues bytes written by the CPU in a small FIFO and serializes them as 8N1 frames on `tx`. Exposes a status word so firmware can poll before writing.

---
 rtl/uart_tx_periph.sv | 143 ++++++++++++++
 tb/tb_uart_tx_periph.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: CPU stores are queued in a small FIFO and
// serialized on tx, with a pollable STATUS word and a sticky overflow flag.
module uart_tx_periph #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [9:0]  BASE_ADDR    = 10'h3F0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  address,
  input  logic [31:0] data_in,
  input  logic [3:0]  width,
  input  logic        write,
  output logic [31:0] data_out,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BaudMax = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DepthC  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q;
  logic [7:0]      shift_q;
  logic [2:0]      bit_idx_q;
  logic [BW-1:0]   baud_q;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            overflow_q;

  logic hit, wr_en, push_req, clr_req, read_status;
  logic fifo_empty, fifo_full, pop, push, ovf_set;
  logic unused_bits;

  assign hit         = (address[9:4] == BASE_ADDR[9:4]);
  assign wr_en       = write & width[0] & hit;
  assign push_req    = wr_en & (address[3:2] == 2'd0);
  assign clr_req     = wr_en & (address[3:2] == 2'd2) & data_in[0];
  assign read_status = hit & (address[3:2] == 2'd1);

  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == DepthC);
  // Pop when idle, or on the last stop-bit cycle so the next start bit follows without a gap.
  assign pop         = !fifo_empty & ((state_q == StIdle) |
                                      ((state_q == StStop) & (baud_q == '0)));
  assign push        = push_req & (!fifo_full | pop);
  assign ovf_set     = push_req & fifo_full & !pop;
  assign busy        = (state_q != StIdle) | !fifo_empty;

  assign unused_bits = ^{data_in[31:8], width[3:1], address[1:0]};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= data_in[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      data_out   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      overflow_q <= ovf_set | (overflow_q & !clr_req);
      data_out   <= read_status ? {23'b0, 5'(count_q), overflow_q, fifo_empty, fifo_full, busy}
                                : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_idx_q <= '0;
      baud_q    <= '0;
      tx        <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx <= 1'b1;
          if (pop) begin
            shift_q <= mem[rd_ptr_q];
            baud_q  <= BaudMax;
            state_q <= StStart;
            tx      <= 1'b0;
          end
        end
        StStart: begin
          if (baud_q == '0) begin
            baud_q    <= BaudMax;
            bit_idx_q <= '0;
            state_q   <= StData;
            tx        <= shift_q[0];
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        StData: begin
          if (baud_q == '0) begin
            baud_q <= BaudMax;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
              tx      <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              tx        <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        StStop: begin
          if (baud_q == '0) begin
            if (pop) begin
              shift_q <= mem[rd_ptr_q];
              baud_q  <= BaudMax;
              state_q <= StStart;
              tx      <= 1'b0;
            end else begin
              state_q <= StIdle;
              tx      <= 1'b1;
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: a frame-level queue model predicts tx, busy and data_out every cycle.
module tb_uart_tx_periph;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 8;
  localparam logic [9:0]  BASE  = 10'h3F0;
  localparam int          FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  address = '0;
  logic [31:0] data_in = '0;
  logic [3:0]  width = '0;
  logic        write = 1'b0;
  logic [31:0] data_out;
  logic        tx, busy;

  always #5 clk = ~clk;

  uart_tx_periph #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .address (address),
    .data_in (data_in),
    .width   (width),
    .write   (write),
    .data_out(data_out),
    .tx      (tx),
    .busy    (busy)
  );

  int total = 0;
  int bad   = 0;

  // Model: queued bytes, cycles left in the current frame (0 = line idle), byte in flight.
  logic [7:0]  q[$];
  int          rem;
  logic [7:0]  cur;
  logic        ovf;
  logic [31:0] exp_dout;

  function automatic logic model_tx();
    int k;
    if (rem == 0) return 1'b1;
    k = (FRAME - rem) / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return cur[k-1];
  endfunction

  function automatic logic model_busy();
    return (rem != 0) || (q.size() != 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    rem = 0;
    ovf = 1'b0;
    cur = '0;
    exp_dout = '0;
  endtask

  task automatic model_edge();
    logic       hit, wr, pop, push_req, clr, new_ovf;
    int         pre;
    logic [4:0] cnt;
    pre = q.size();
    cnt = 5'(pre);
    hit = (address[9:4] == BASE[9:4]);
    wr  = write && width[0] && hit;
    push_req = wr && (address[3:0] == 4'h0);
    clr      = wr && (address[3:0] == 4'h8) && data_in[0];
    exp_dout = (hit && address[3:0] == 4'h4) ?
               {23'b0, cnt, ovf, pre == 0, pre == DEPTH, model_busy()} : 32'h0;
    pop = (pre > 0) && (rem <= 1);
    if (pop) begin
      cur = q.pop_front();
      rem = FRAME;
    end else if (rem > 0) begin
      rem--;
    end
    new_ovf = 1'b0;
    if (push_req) begin
      if (pre < DEPTH || pop) q.push_back(data_in[7:0]);
      else new_ovf = 1'b1;
    end
    ovf = new_ovf | (ovf & !clr);
  endtask

  task automatic step(input logic w, input logic [9:0] a, input logic [31:0] d,
                      input logic [3:0] wd);
    write = w; address = a; data_in = d; width = wd;
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge();
    #1;
    check("tx", {31'b0, tx}, {31'b0, model_tx()});
    check("busy", {31'b0, busy}, {31'b0, model_busy()});
    check("data_out", data_out, exp_dout);
  endtask

  task automatic idle(input int n, input logic [9:0] a);
    repeat (n) step(1'b0, a, 32'h0, 4'h0);
  endtask

  logic [9:0] addr_pool [6] = '{10'h3F0, 10'h3F4, 10'h3F8, 10'h3FC, 10'h3E0, 10'h3F0};

  initial begin
    model_reset();
    // Writes during reset must be ignored.
    repeat (4) step(1'b1, 10'h3F0, 32'h5A, 4'hF);
    reset_n = 1'b1;
    step(1'b0, 10'h3F4, 32'h0, 4'h0);
    check("status_after_reset", data_out, 32'h4);

    // Single byte.
    step(1'b1, 10'h3F0, 32'hA5, 4'h1);
    idle(170, 10'h3F4);

    // Three back-to-back frames.
    step(1'b1, 10'h3F0, 32'h11, 4'hF);
    step(1'b1, 10'h3F0, 32'h22, 4'hF);
    step(1'b1, 10'h3F0, 32'h33, 4'hF);
    idle(490, 10'h3F4);

    // Overflow: ten pushes in a row, one dropped.
    for (int i = 0; i < 10; i++) step(1'b1, 10'h3F0, 32'(8'h40 + i), 4'h1);
    step(1'b0, 10'h3F4, 32'h0, 4'h0);
    check("ovf_set", {31'b0, data_out[3]}, 32'h1);
    idle(9 * FRAME + 4, 10'h3F4);
    step(1'b1, 10'h3F8, 32'h1, 4'h1);
    step(1'b0, 10'h3F4, 32'h0, 4'h0);
    check("ovf_cleared", {31'b0, data_out[3]}, 32'h0);

    // Decode and byte-enable filtering.
    step(1'b1, 10'h3F0, 32'h77, 4'b0010);
    step(1'b1, 10'h3E0, 32'h77, 4'hF);
    step(1'b0, 10'h3F8, 32'h0, 4'h0);
    check("read_ctrl_zero", data_out, 32'h0);
    idle(20, 10'h3F4);

    // Reset in the middle of the data bits.
    step(1'b1, 10'h3F0, 32'($urandom_range(0, 255)), 4'h1);
    idle(CPB + 3 * CPB + 5, 10'h3F0);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check("reset_tx", {31'b0, tx}, 32'h1);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_dout", data_out, 32'h0);
    step(1'b1, 10'h3F0, 32'h99, 4'hF);
    step(1'b0, 10'h3F4, 32'h0, 4'h0);
    reset_n = 1'b1;
    step(1'b0, 10'h3F4, 32'h0, 4'h0);
    check("status_after_midreset", data_out, 32'h4);
    idle(200, 10'h3F4);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 15);
      step(r < 4, addr_pool[$urandom_range(0, 5)], $urandom, 4'($urandom));
    end
    idle(DEPTH * FRAME + 200, 10'h3F4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
